// File: rtl/swap_pkg.sv
// Shared constants for the register-swap sequencer: default widths and FSM encoding.
package swap_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RDA  = 2'd1;
  localparam logic [1:0] ST_MOVB = 2'd2;
  localparam logic [1:0] ST_WRB  = 2'd3;

  function automatic logic state_busy(input logic [1:0] st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/swap_req_fifo.sv
// Two-entry request queue holding {a, b} address pairs for the swap sequencer.
module swap_req_fifo #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/swap_sequencer.sv
// Swaps two registers of an external register file through its single read and
// write port, borrowing the CPU's port slots while a queued swap is in flight.
//
// state | meaning
// IDLE  | CPU owns the ports; pops next request (a==b completes here)
// RDA   | read reg a into temp
// MOVB  | read reg b, write it into reg a
// WRB   | write temp into reg b, signal done
module swap_sequencer
  import swap_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_a,
  input  logic [AW-1:0] req_b,
  input  logic [AW-1:0] cpu_ra1,
  input  logic [AW-1:0] cpu_wa,
  input  logic [DW-1:0] cpu_wd,
  input  logic          cpu_we,
  output logic          cpu_stall,
  output logic [AW-1:0] rf_ra1,
  input  logic [DW-1:0] rf_rd1,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          rf_we,
  output logic          busy,
  output logic          done,
  output logic [7:0]    swap_cnt
);

  logic [1:0]      state;
  logic [AW-1:0]   cur_a;
  logic [AW-1:0]   cur_b;
  logic [DW-1:0]   temp;
  logic [2*AW-1:0] head;
  logic [AW-1:0]   head_a;
  logic [AW-1:0]   head_b;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  swap_req_fifo #(.W(2*AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({req_a, req_b}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a    = head[2*AW-1:AW];
  assign head_b    = head[AW-1:0];
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = state_busy(state);
  assign cpu_stall = busy || !fifo_empty;
  // a degenerate request completes in its own pop cycle
  assign done      = (state == ST_WRB) || (pop && (head_a == head_b));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cur_a    <= '0;
      cur_b    <= '0;
      temp     <= '0;
      swap_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            cur_a <= head_a;
            cur_b <= head_b;
            if (head_a != head_b) state <= ST_RDA;
            else                  swap_cnt <= swap_cnt + 8'd1;
          end
        end
        ST_RDA: begin
          temp  <= rf_rd1;
          state <= ST_MOVB;
        end
        ST_MOVB: state <= ST_WRB;
        ST_WRB: begin
          state    <= ST_IDLE;
          swap_cnt <= swap_cnt + 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_ra1 = cpu_ra1;
    rf_wa  = cpu_wa;
    rf_wd  = cpu_wd;
    rf_we  = cpu_we && !cpu_stall;
    case (state)
      ST_RDA: begin
        rf_ra1 = cur_a;
        rf_wa  = cur_a;
        rf_wd  = temp;
        rf_we  = 1'b0;
      end
      ST_MOVB: begin
        rf_ra1 = cur_b;
        rf_wa  = cur_a;
        rf_wd  = rf_rd1;
        rf_we  = 1'b1;
      end
      ST_WRB: begin
        rf_ra1 = cur_b;
        rf_wa  = cur_b;
        rf_wd  = temp;
        rf_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swap_sequencer.sv
// Scoreboard bench for swap_sequencer with a behavioural external register file.
module tb_swap_sequencer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_a;
  logic [4:0]  req_b;
  logic [4:0]  cpu_ra1;
  logic [4:0]  cpu_wa;
  logic [31:0] cpu_wd;
  logic        cpu_we;
  logic        cpu_stall;
  logic [4:0]  rf_ra1;
  logic [31:0] rf_rd1;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        rf_we;
  logic        busy;
  logic        done;
  logic [7:0]  swap_cnt;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  logic [31:0] regs   [32];
  logic [31:0] shadow [32];
  int          exp_cnt;
  int          tests;
  int          fails;

  swap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .cpu_ra1   (cpu_ra1),
    .cpu_wa    (cpu_wa),
    .cpu_wd    (cpu_wd),
    .cpu_we    (cpu_we),
    .cpu_stall (cpu_stall),
    .rf_ra1    (rf_ra1),
    .rf_rd1    (rf_rd1),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .rf_we     (rf_we),
    .busy      (busy),
    .done      (done),
    .swap_cnt  (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) if (rf_we) regs[rf_wa] <= rf_wd;
  assign rf_rd1 = regs[rf_ra1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // Issue one request; expected writes and done come from the shadow model.
  task automatic send(input int a, input int b);
    logic [31:0] t;
    bit acc = 0;
    if (a != b) begin
      wq.push_back('{addr: 5'(a), data: shadow[b]});
      wq.push_back('{addr: 5'(b), data: shadow[a]});
      t = shadow[a]; shadow[a] = shadow[b]; shadow[b] = t;
    end
    dq.push_back(exp_cnt);
    exp_cnt = (exp_cnt + 1) % 256;
    req_a = 5'(a); req_b = 5'(b); req_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (req_ready) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) timeout("req_accept");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!cpu_stall && !busy) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_idle");
    @(negedge clk);
    check("queue_drain", 32'(wq.size() + dq.size()), 32'd0);
  endtask

  initial begin
    int nb;
    int done_k;
    logic [31:0] old9;
    tests = 0; fails = 0; exp_cnt = 0;
    rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    cpu_ra1 = '0; cpu_wa = '0; cpu_wd = '0; cpu_we = 1'b0;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_cnt", 32'(swap_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          if (rf_we === 1'b1) begin
            if (wq.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_write: addr %0d data %h, none expected", rf_wa, rf_wd);
            end else begin
              automatic wr_t w = wq.pop_front();
              check("wr_addr", 32'(rf_wa), 32'(w.addr));
              check("wr_data", rf_wd, w.data);
            end
          end
          if (done === 1'b1) begin
            if (dq.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_done: swap_cnt %0d, none expected", swap_cnt);
            end else begin
              check("done_cnt", 32'(swap_cnt), 32'(dq.pop_front()));
            end
          end
        end
      end
    join_none

    // preload the register file through the CPU write port
    cpu_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      shadow[i] = (i == 3) ? 32'hAAAA0003 : (i == 7) ? 32'h77770007 : 32'h1000_0000 + 32'(i);
      cpu_wa = 5'(i); cpu_wd = shadow[i];
      wq.push_back('{addr: 5'(i), data: shadow[i]});
      @(posedge clk); #1;
    end
    cpu_we = 1'b0;
    wait_idle();

    // basic swap (3,7): done three cycles after the pop cycle, busy for 3
    send(3, 7);
    nb = 0; done_k = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done && done_k < 0) done_k = k;
    end
    check("swap37_busy_cycles", 32'(nb), 32'd3);
    check("swap37_done_cycle", 32'(done_k), 32'd3);
    check("swap37_r3", regs[3], 32'h77770007);
    check("swap37_r7", regs[7], 32'hAAAA0003);
    check("swap37_cnt", 32'(swap_cnt), 32'd1);

    // degenerate request: done in the pop cycle, no write
    send(5, 5);
    @(negedge clk);
    check("deg_done", 32'(done), 32'd1);
    check("deg_busy", 32'(busy), 32'd0);
    wait_idle();
    check("deg_r5", regs[5], 32'h10000005);
    check("deg_cnt", 32'(swap_cnt), 32'd2);

    // back-to-back requests fill the queue
    send(1, 2);
    send(3, 4);
    send(5, 6);
    check("b2b_ready_low", 32'(req_ready), 32'd0);
    wait_idle();
    check("b2b_cnt", 32'(swap_cnt), 32'd5);
    for (int i = 1; i <= 6; i++) check("b2b_reg", regs[i], shadow[i]);

    // CPU write held off behind a queued swap
    old9 = shadow[9];
    send(10, 11);
    cpu_we = 1'b1; cpu_wa = 5'd9; cpu_wd = 32'h1234;
    wq.push_back('{addr: 5'd9, data: 32'h1234});
    shadow[9] = 32'h1234;
    #1 check("cpu_stall_high", 32'(cpu_stall), 32'd1);
    begin
      bit ok = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!cpu_stall) begin ok = 1; break; end
      end
      if (!ok) timeout("cpu_unstall");
    end
    check("cpu_r9_held", regs[9], old9);
    @(posedge clk); #1 cpu_we = 1'b0;
    check("cpu_r9_written", regs[9], 32'h1234);
    wait_idle();
    check("cpu_cnt", 32'(swap_cnt), 32'd6);

    // reset in MOVB aborts the swap; no expectations are queued for it
    req_a = 5'd12; req_b = 5'd13; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_we", 32'(rf_we), 32'd0);
    check("abort_cnt", 32'(swap_cnt), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    check("abort_stall", 32'(cpu_stall), 32'd0);
    check("abort_r12", regs[12], shadow[12]);
    check("abort_r13", regs[13], shadow[13]);
    check("abort_cnt_after", 32'(swap_cnt), 32'd0);

    // 256 swaps wrap the counter back to 0
    for (int i = 0; i < 256; i++) send(i % 32, (i * 5 + 1) % 32);
    wait_idle();
    check("wrap_cnt", 32'(swap_cnt), 32'd0);
    for (int i = 0; i < 32; i++) check("final_reg", regs[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
